// File: rtl/control_seq_if.sv
// Instruction/strobe bundle between the IR, the sequencer and the datapath.
// The sequencer uses the slave view; the IR/datapath side uses the master view.
interface control_seq_if #(
  parameter int NSIG = 8
);
  logic [7:0]      inst;
  logic            inst_valid;
  logic            carry;
  logic            mem_ready;
  logic            irq;
  logic            cycle;
  logic            stall;
  logic            M, MW, MC, J, LJ, RD, WR, Y, WA, WC, ISP;
  logic            CLI, LJR;
  logic [1:0]      RS;
  logic [3:0]      ALU;
  logic [NSIG-1:0] sig;
  logic            ie;
  logic            irq_take;

  modport master (
    output inst, inst_valid, carry, mem_ready, irq,
    input  cycle, stall, M, MW, MC, J, LJ, RD, WR, Y, WA, WC, ISP,
    input  CLI, LJR, RS, ALU, sig, ie, irq_take
  );

  modport slave (
    input  inst, inst_valid, carry, mem_ready, irq,
    output cycle, stall, M, MW, MC, J, LJ, RD, WR, Y, WA, WC, ISP,
    output CLI, LJR, RS, ALU, sig, ie, irq_take
  );
endinterface

// File: rtl/control_seq.sv
// Sequenced control unit: FETCH/WAIT/EXEC phasing, memory wait states,
// carry latch for conditional jumps, one-hot signal pulses and interrupt take.
module control_seq #(
  parameter int MEM_WAIT = 0,
  parameter int NSIG     = 8
) (
  input logic          clk,
  input logic          rst,
  control_seq_if.slave bus
);
  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  typedef enum logic [1:0] {FETCH, WAIT, EXEC} seqState;

  seqState       stateReg;
  logic [CW-1:0] waitCntReg;
  logic          ieReg;
  logic          cjReg;

  logic [7:0] i;
  logic       inFetch, inWait, inExec;
  logic       live, takeIrq, strobeEn;
  logic       lHit, sigHit, cliHit, stiHit;
  logic       mDec, ispDec, aDec;

  assign i       = bus.inst;
  assign inFetch = (stateReg == FETCH);
  assign inWait  = (stateReg == WAIT);
  assign inExec  = (stateReg == EXEC);

  assign live     = bus.inst_valid & ~rst;
  assign takeIrq  = bus.irq & ieReg & bus.inst_valid & inFetch;
  // Wait states and the interrupt-take cycle carry no strobes at all.
  assign strobeEn = live & ~takeIrq & ~inWait;

  assign lHit   = ~i[7] & ~i[6] & ~i[5] & i[4] & ~i[3];
  assign sigHit = ~i[7] & ~i[6] & ~i[5] & i[4] & i[3];
  assign cliHit = lHit & i[1];
  assign stiHit = lHit & ~i[1] & i[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= FETCH;
      waitCntReg <= '0;
      ieReg      <= 1'b0;
      cjReg      <= 1'b0;
    end else if (bus.inst_valid) begin
      case (stateReg)
        FETCH: begin
          if (takeIrq) begin
            // Instruction is re-presented by the IR after the take cycle.
            ieReg <= 1'b0;
          end else begin
            cjReg <= bus.carry;
            if (cliHit) begin
              ieReg <= 1'b0;
            end else if (stiHit) begin
              ieReg <= 1'b1;
            end
            if (i[7]) begin
              if (MEM_WAIT > 0) begin
                stateReg   <= WAIT;
                waitCntReg <= CW'(MEM_WAIT - 1);
              end else begin
                stateReg <= EXEC;
              end
            end
          end
        end
        WAIT: begin
          if (waitCntReg == '0) begin
            stateReg <= EXEC;
          end else begin
            waitCntReg <= waitCntReg - 1'b1;
          end
        end
        EXEC: begin
          if (bus.mem_ready) begin
            stateReg <= FETCH;
          end
        end
        default: stateReg <= FETCH;
      endcase
    end
  end

  assign mDec   = i[7] & ~i[6] & inExec;
  assign ispDec = ~(~i[7] & ~i[6] & i[5]);
  assign aDec   = (i[6] & ~i[7]) | (inExec & i[6] & ~i[5]);

  assign bus.cycle    = live & inExec;
  assign bus.stall    = live & (takeIrq | (inFetch & i[7]) | inWait | (inExec & ~bus.mem_ready));
  assign bus.ie       = live & ieReg;
  assign bus.irq_take = ~rst & takeIrq;

  assign bus.M   = strobeEn & mDec;
  assign bus.MW  = strobeEn & mDec & i[5];
  assign bus.MC  = strobeEn & i[7] & inFetch;
  assign bus.J   = strobeEn & i[7] & i[6] & i[5] & inExec & ~(cjReg & i[4]);
  assign bus.LJ  = strobeEn & lHit;
  assign bus.CLI = strobeEn & cliHit;
  assign bus.LJR = strobeEn & lHit & i[2];
  assign bus.RD  = strobeEn & ~i[7] & ~i[6] & ~i[5] & ~i[4] & i[2];
  assign bus.WR  = strobeEn & ~i[7] & ~i[6] & ~i[5] & ~i[4] & i[3];
  assign bus.ISP = strobeEn & ispDec;
  assign bus.WA  = strobeEn & ((mDec & ~i[5]) | (aDec & ~(i[4] & ~i[3])));
  assign bus.WC  = strobeEn & (aDec | ~ispDec) & i[4];

  // These three follow the instruction regardless of reset or bubbles.
  assign bus.Y   = i[5];
  assign bus.RS  = i[1:0];
  assign bus.ALU = i[6] ? i[3:0] : {~i[7], 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < NSIG; gi++) begin : g_sig
      assign bus.sig[gi] = strobeEn & sigHit & (i[2:0] == 3'(gi));
    end
  endgenerate
endmodule

// File: tb/tb_control_seq.sv
// Bench for control_seq: directed vector table, hand sequences for the
// multi-cycle cases, then random stimulus against a cycle-position model.
module tb_control_seq;
  typedef struct packed {
    logic       cycle, stall, M, MW, MC, J, LJ, RD, WR, Y, WA, WC, ISP, CLI, LJR;
    logic [1:0] RS;
    logic [3:0] ALU;
    logic [7:0] sig;
    logic       ie, irqTake;
  } outs_t;

  // Key fields: cycle stall M MW MC J LJ CLI WA ie irqTake, then sig.
  typedef struct packed {
    logic [10:0] flags;
    logic [7:0]  sig;
  } key_t;

  typedef struct {
    logic [7:0] inst;
    logic       valid, carry, mr, irq, rst;
    key_t       exp;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic rstA, rstB;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  control_seq_if #(.NSIG(8)) busA();
  control_seq_if #(.NSIG(4)) busB();

  control_seq #(.MEM_WAIT(0), .NSIG(8)) dutA (.clk(clk), .rst(rstA), .bus(busA));
  control_seq #(.MEM_WAIT(2), .NSIG(4)) dutB (.clk(clk), .rst(rstB), .bus(busB));

  outs_t actA, actB;
  assign actA = {busA.cycle, busA.stall, busA.M, busA.MW, busA.MC, busA.J, busA.LJ, busA.RD,
                 busA.WR, busA.Y, busA.WA, busA.WC, busA.ISP, busA.CLI, busA.LJR, busA.RS,
                 busA.ALU, busA.sig, busA.ie, busA.irq_take};
  assign actB = {busB.cycle, busB.stall, busB.M, busB.MW, busB.MC, busB.J, busB.LJ, busB.RD,
                 busB.WR, busB.Y, busB.WA, busB.WC, busB.ISP, busB.CLI, busB.LJR, busB.RS,
                 busB.ALU, 4'b0000, busB.sig, busB.ie, busB.irq_take};

  function automatic key_t keyOf(outs_t o);
    key_t k;
    k.flags = {o.cycle, o.stall, o.M, o.MW, o.MC, o.J, o.LJ, o.CLI, o.WA, o.ie, o.irqTake};
    k.sig   = o.sig;
    return k;
  endfunction

  task automatic chkKey(string name, key_t act, key_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual flags=%b sig=%h required flags=%b sig=%h",
               name, act.flags, act.sig, exp.flags, exp.sig);
    end
  endtask

  task automatic chkFull(string name, int cyc, outs_t act, outs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic driveA(logic [7:0] inst, logic v, logic c, logic mr, logic irq, logic r);
    busA.inst = inst; busA.inst_valid = v; busA.carry = c;
    busA.mem_ready = mr; busA.irq = irq; rstA = r;
  endtask

  task automatic driveB(logic [7:0] inst, logic v, logic c, logic mr, logic irq, logic r);
    busB.inst = inst; busB.inst_valid = v; busB.carry = c;
    busB.mem_ready = mr; busB.irq = irq; rstB = r;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic stepB(string name, logic [7:0] inst, logic mr, logic r, logic [10:0] flags, logic [7:0] sig);
    key_t e;
    driveB(inst, 1'b1, 1'b0, mr, 1'b0, r);
    #2;
    e.flags = flags;
    e.sig   = sig;
    chkKey(name, keyOf(actB), e);
    nextCycle();
  endtask

  // Reference: pos counts cycles into the current instruction (0 = first cycle).
  int   pos[2];
  logic mIe[2], mCj[2];

  function automatic outs_t modelOut(int memWait, int nsig, logic [7:0] i, logic v, logic mr,
                                     logic irq, logic r, int p, logic ie, logic cj);
    outs_t o;
    logic  ex, wt, lj, a, isp;
    o     = '0;
    o.Y   = i[5];
    o.RS  = i[1:0];
    o.ALU = i[6] ? i[3:0] : {~i[7], 3'b000};
    if (r || !v) return o;
    o.ie = ie;
    if (irq && ie && p == 0) begin
      o.stall   = 1'b1;
      o.irqTake = 1'b1;
      return o;
    end
    wt = (p >= 1) && (p <= memWait);
    ex = (p > memWait);
    if (wt) begin
      o.stall = 1'b1;
      return o;
    end
    o.cycle = ex;
    o.stall = ex ? !mr : i[7];
    lj      = (i[7:3] == 5'b00010);
    o.LJ    = lj;
    o.CLI   = lj && i[1];
    o.LJR   = lj && i[2];
    o.RD    = (i[7:4] == 4'b0000) && i[2];
    o.WR    = (i[7:4] == 4'b0000) && i[3];
    o.M     = (i[7:6] == 2'b10) && ex;
    o.MW    = o.M && i[5];
    o.MC    = i[7] && !ex;
    o.J     = (i[7:5] == 3'b111) && ex && !(cj && i[4]);
    isp     = (i[7:5] != 3'b001);
    o.ISP   = isp;
    a       = (i[7:6] == 2'b01) || (ex && i[6:5] == 2'b10);
    o.WA    = (o.M && !i[5]) || (a && i[4:3] != 2'b10);
    o.WC    = (a || !isp) && i[4];
    if (i[7:3] == 5'b00011 && int'(i[2:0]) < nsig) o.sig[i[2:0]] = 1'b1;
    return o;
  endfunction

  task automatic modelAdv(int k, int memWait, logic [7:0] i, logic v, logic c, logic mr,
                          logic irq, logic r);
    if (r) begin
      pos[k] = 0; mIe[k] = 1'b0; mCj[k] = 1'b0;
      return;
    end
    if (!v) return;
    if (irq && mIe[k] && pos[k] == 0) begin
      mIe[k] = 1'b0;
      return;
    end
    if (pos[k] == 0) mCj[k] = c;
    if (i[7:3] == 5'b00010) begin
      if (i[1]) mIe[k] = 1'b0;
      else if (i[0]) mIe[k] = 1'b1;
    end
    if (!i[7]) pos[k] = 0;
    else if (pos[k] > memWait) begin
      if (mr) pos[k] = 0;
    end else pos[k] = pos[k] + 1;
  endtask

  vec_t vecs[15];

  initial begin
    logic [7:0] rInst[2];
    logic       rV[2], rC[2], rMr[2], rIrq[2], rR[2], hold[2];
    outs_t      eA, eB;

    vecs[0]  = '{8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, key_t'({11'b00000000000, 8'h00}), "reset_outputs"};
    vecs[1]  = '{8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, key_t'({11'b01001000000, 8'h00}), "a3_fetch"};
    vecs[2]  = '{8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, key_t'({11'b10110000000, 8'h00}), "a3_exec"};
    vecs[3]  = '{8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, key_t'({11'b01001000000, 8'h00}), "f0_fetch"};
    vecs[4]  = '{8'hF0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, key_t'({11'b10000000000, 8'h00}), "f0_exec_nojump"};
    vecs[5]  = '{8'hE0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, key_t'({11'b01001000000, 8'h00}), "e0_fetch"};
    vecs[6]  = '{8'hE0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, key_t'({11'b10000100000, 8'h00}), "e0_exec_jump"};
    vecs[7]  = '{8'h1D, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, key_t'({11'b00000000000, 8'h20}), "sig5"};
    vecs[8]  = '{8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, key_t'({11'b00000010000, 8'h00}), "sti"};
    vecs[9]  = '{8'h40, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, key_t'({11'b01000000011, 8'h00}), "irq_take"};
    vecs[10] = '{8'h40, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, key_t'({11'b00000000100, 8'h00}), "irq_masked"};
    vecs[11] = '{8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, key_t'({11'b00000011000, 8'h00}), "cli"};
    vecs[12] = '{8'hA3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, key_t'({11'b00000000000, 8'h00}), "bubble"};
    vecs[13] = '{8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, key_t'({11'b01001000000, 8'h00}), "after_bubble_fetch"};
    vecs[14] = '{8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, key_t'({11'b10110000000, 8'h00}), "after_bubble_exec"};

    driveA(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    driveB(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    nextCycle();
    nextCycle();

    for (int n = 0; n < 15; n++) begin
      driveA(vecs[n].inst, vecs[n].valid, vecs[n].carry, vecs[n].mr, vecs[n].irq, vecs[n].rst);
      #2;
      chkKey(vecs[n].name, keyOf(actA), vecs[n].exp);
      nextCycle();
    end

    // MEM_WAIT=2 / NSIG=4 instance: wait states, EXEC hold, narrow sig bus, reset abort.
    driveA(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    driveB(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    nextCycle();
    stepB("w83_fetch",     8'h83, 1'b1, 1'b0, 11'b01001000000, 8'h00);
    stepB("w83_wait1",     8'h83, 1'b1, 1'b0, 11'b01000000000, 8'h00);
    stepB("w83_wait2",     8'h83, 1'b1, 1'b0, 11'b01000000000, 8'h00);
    stepB("w83_exec_hold", 8'h83, 1'b0, 1'b0, 11'b11100000100, 8'h00);
    stepB("w83_exec_done", 8'h83, 1'b1, 1'b0, 11'b10100000100, 8'h00);
    stepB("nsig4_idx5",    8'h1D, 1'b1, 1'b0, 11'b00000000000, 8'h00);
    stepB("nsig4_idx3",    8'h1B, 1'b1, 1'b0, 11'b00000000000, 8'h08);
    stepB("a0_fetch",      8'hA0, 1'b1, 1'b0, 11'b01001000000, 8'h00);
    stepB("a0_wait",       8'hA0, 1'b1, 1'b0, 11'b01000000000, 8'h00);
    stepB("a0_rst",        8'hA0, 1'b1, 1'b1, 11'b00000000000, 8'h00);
    stepB("a0_refetch",    8'hA0, 1'b1, 1'b0, 11'b01001000000, 8'h00);
    stepB("a0_wait1",      8'hA0, 1'b1, 1'b0, 11'b01000000000, 8'h00);
    stepB("a0_wait2",      8'hA0, 1'b1, 1'b0, 11'b01000000000, 8'h00);
    stepB("a0_exec",       8'hA0, 1'b1, 1'b0, 11'b10110000000, 8'h00);

    // Random phase: a new instruction is offered only when the last cycle did not stall.
    for (int k = 0; k < 2; k++) hold[k] = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        rR[k]   = (cyc == 0) || ($urandom_range(0, 59) == 0);
        rC[k]   = 1'($urandom_range(0, 1));
        rMr[k]  = ($urandom_range(0, 3) != 0);
        rIrq[k] = ($urandom_range(0, 3) == 0);
        if (!hold[k]) begin
          rV[k] = ($urandom_range(0, 7) != 0);
          case ($urandom_range(0, 9))
            0:       rInst[k] = 8'h11;
            1:       rInst[k] = 8'h15;
            2:       rInst[k] = 8'h12;
            default: rInst[k] = 8'($urandom);
          endcase
        end
      end
      driveA(rInst[0], rV[0], rC[0], rMr[0], rIrq[0], rR[0]);
      driveB(rInst[1], rV[1], rC[1], rMr[1], rIrq[1], rR[1]);
      #2;
      eA = modelOut(0, 8, rInst[0], rV[0], rMr[0], rIrq[0], rR[0], pos[0], mIe[0], mCj[0]);
      eB = modelOut(2, 4, rInst[1], rV[1], rMr[1], rIrq[1], rR[1], pos[1], mIe[1], mCj[1]);
      chkFull("rand_a", cyc, actA, eA);
      chkFull("rand_b", cyc, actB, eB);
      hold[0] = eA.stall;
      hold[1] = eB.stall;
      nextCycle();
      modelAdv(0, 0, rInst[0], rV[0], rC[0], rMr[0], rIrq[0], rR[0]);
      modelAdv(1, 2, rInst[1], rV[1], rC[1], rMr[1], rIrq[1], rR[1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
